bus_master_arbiter: RTL and testbench
=====================================

# bus_master_arbiter

Shares the rv32 peripheral bus between the CPU and one external bus master (UART debug bridge or DMA engine). It sits between the CPU core and the register/RAM decode. The CPU owns the bus by default. On an external request the arbiter halts the CPU, waits for in-flight peripheral activity to drain, grants the bus, and runs single-beat external transactions. It returns the bus on release or after a burst limit.

## Interface
- `MAX_BURST`, 16: external transactions per grant before a forced CPU slot; 0 = unlimited.
- `CPU_SLOT`, 4: cycles the CPU owns the bus after a forced release; must be ≥1.
- `address_width`, `data_width`: taken from `cpu_reg_package`, not parameters.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `cpu_address_i`  in  address_width  CPU address.
- `cpu_we_i`  in  1  CPU write strobe.
- `cpu_we_ram_i`  in  4  CPU RAM byte enables.
- `cpu_data_i`  in  data_width  CPU write data.
- `cpu_halt_o`  out  1  stall request to the CPU core.
- `ext_req_i`  in  1  external master wants the bus; level.
- `ext_gnt_o`  out  1  external master owns the bus.
- `ext_valid_i`  in  1  external transaction request.
- `ext_ready_o`  out  1  external transaction accepted when `valid & ready`.
- `ext_address_i`  in  address_width  external address.
- `ext_we_i`  in  1  external write (1) / read (0).
- `ext_wdata_i`  in  data_width  external write data.
- `ext_rdata_o`  out  data_width  captured bus read data.
- `ext_rvalid_o`  out  1  one-cycle completion pulse, for reads and writes.
- `bus_address_o`  out  address_width  shared bus address.
- `bus_we_o`  out  1  shared bus write strobe.
- `bus_we_ram_o`  out  4  shared bus RAM byte enables.
- `bus_data_o`  out  data_width  shared bus write data.
- `bus_rdata_i`  in  data_width  decoded read word.
- `module_busy_i`  in  1  a peripheral is mid-operation.

## Operation
States: `CPU`, `DRAIN`, `EXT_IDLE`, `EXT_ACC`, `EXT_RESP`, `COOL`.

- **CPU:**
  - Bus outputs pass the `cpu_*` inputs through combinationally.
  - `ext_req_i` high → `DRAIN`.
- **DRAIN:**
  - `cpu_halt_o` is 1 and CPU signals still pass through, so an in-flight access completes.
  - Exit to `EXT_IDLE` once ≥2 cycles have elapsed in `DRAIN` and `module_busy_i`=0.
  - If `ext_req_i` drops while in `DRAIN` → `CPU`.
- **EXT_IDLE:**
  - `ext_gnt_o`=1 and `ext_ready_o`=1.
  - Bus outputs: `bus_we_o`=0, `bus_we_ram_o`=0; address and data hold their last values.
  - `valid & ready` latches address, we and wdata → `EXT_ACC`.
  - `ext_req_i`=0 with no accept → `CPU`.
- **EXT_ACC:**
  - Drives the latched address for exactly one cycle.
  - If a write: `bus_we_o`=1, `bus_we_ram_o`=4'hF.
  - → `EXT_RESP`.
- **EXT_RESP:**
  - Bus write strobes are 0.
  - When `module_busy_i`=0: capture `bus_rdata_i` into `ext_rdata_o`, increment the burst count, pulse `ext_rvalid_o` on the next cycle, then:
    - → `COOL` if count = `MAX_BURST` (and `MAX_BURST`≠0);
    - otherwise → `EXT_IDLE`.
  - `module_busy_i` high holds this state indefinitely.
- **COOL:**
  - `cpu_halt_o`=0, `ext_gnt_o`=0, CPU pass-through.
  - Stays `CPU_SLOT` cycles, then → `DRAIN` if `ext_req_i`, else → `CPU`.
  - Burst count clears on entry to `COOL` or `CPU`.
- **Release mid-transaction:** `ext_req_i` dropping in `EXT_ACC`/`EXT_RESP` does not abort; the transaction completes, then `EXT_IDLE` releases.
- **Invalid requests:** `ext_valid_i` outside `EXT_IDLE` is ignored (ready=0).

## Timing
- All state, `cpu_halt_o`, `ext_gnt_o`, `ext_rdata_o` and `ext_rvalid_o` are registered.
- `ext_ready_o` and bus muxing are decoded from state.
- Request at t (in `CPU`) → `cpu_halt_o` at t+1 → `ext_gnt_o` no earlier than t+3.
- Accept at t → bus access at t+1 → capture at t+2 (if not busy) → `ext_rvalid_o` and `ext_ready_o` at t+3.
- Peak throughput: one transaction per 3 cycles.
- `cpu_halt_o` is 1 in `DRAIN`, `EXT_*`; 0 in `CPU`, `COOL`.
- Reset (any state): next cycle state = `CPU`; all outputs 0 except bus pass-through of CPU; counters 0; `ext_rdata_o`=0. A transaction in progress at reset is dropped with no `ext_rvalid_o`.
- Counter widths: burst `$clog2(MAX_BURST+1)`, slot `$clog2(CPU_SLOT+1)`, both unsigned.

## Structure
- Add `bus_arb_state_t` (enum of the six states) to `cpu_reg_package`; reuse `address_width`/`data_width` there.
- No sub-module: one FSM, two counters, one transaction latch, one output mux.
- Top level connects `bus_*` to the `from_cpu`-side signals of the `bus_rv32` interface.

## Test plan
- **Idle CPU path:** no `ext_req_i`; CPU writes 0xDEADBEEF to 0x0100 → identical `bus_*` values same cycle; `cpu_halt_o`=0 throughout.
- **Grant with drain:** `ext_req_i`=1 while `module_busy_i`=1 for 5 cycles → `cpu_halt_o` at t+1, `ext_gnt_o` only after busy falls, never earlier than t+3.
- **External read:** ext read at 0x0040, `bus_rdata_i`=0x12345678 → `bus_we_o`=0 for one `EXT_ACC` cycle; `ext_rvalid_o` pulse at t+3 with `ext_rdata_o`=0x12345678.
- **Burst limit:** `MAX_BURST`=2, `CPU_SLOT`=4, three back-to-back writes → after the 2nd `ext_rvalid_o`, gnt and halt drop for exactly 4 cycles, then re-drain and the 3rd write completes.
- **Release and busy stretch:** `ext_req_i` dropped during `EXT_RESP` with `module_busy_i` high 3 cycles → rvalid still pulses, then state `CPU`, halt 0.
- **Reset mid-operation:** `reset_i` asserted in `EXT_ACC` → next cycle gnt=0, halt=0, rvalid=0, CPU pass-through restored.

Source files
------------

// File: rtl/cpu_reg_package.sv
// Shared register-bus definitions for the rv32 peripheral bus.
// Holds the bus widths and the state encoding of the bus master arbiter.
package cpu_reg_package;

  localparam int address_width = 32;
  localparam int data_width    = 32;

  typedef enum logic [2:0] {
    ARB_CPU      = 3'd0,
    ARB_DRAIN    = 3'd1,
    ARB_EXT_IDLE = 3'd2,
    ARB_EXT_ACC  = 3'd3,
    ARB_EXT_RESP = 3'd4,
    ARB_COOL     = 3'd5
  } bus_arb_state_t;

endpackage

// File: rtl/bus_master_arbiter.sv
// Shares the peripheral bus between the CPU and one external master: halts the CPU,
// drains in-flight activity, then runs single-beat external transactions.
module bus_master_arbiter
  import cpu_reg_package::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOT  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic                     cpu_we_i,
  input  logic [3:0]               cpu_we_ram_i,
  input  logic [data_width-1:0]    cpu_data_i,
  output logic                     cpu_halt_o,
  input  logic                     ext_req_i,
  output logic                     ext_gnt_o,
  input  logic                     ext_valid_i,
  output logic                     ext_ready_o,
  input  logic [address_width-1:0] ext_address_i,
  input  logic                     ext_we_i,
  input  logic [data_width-1:0]    ext_wdata_i,
  output logic [data_width-1:0]    ext_rdata_o,
  output logic                     ext_rvalid_o,
  output logic [address_width-1:0] bus_address_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_we_ram_o,
  output logic [data_width-1:0]    bus_data_o,
  input  logic [data_width-1:0]    bus_rdata_i,
  input  logic                     module_busy_i
);

  localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int SLOT_W  = $clog2(CPU_SLOT + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(CPU_SLOT - 1);

  bus_arb_state_t           state_q, state_d;
  logic [BURST_W-1:0]       burst_q, burst_d, burst_inc;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic                     halt_q, gnt_q, rvalid_q;
  logic [data_width-1:0]    rdata_q;
  logic [address_width-1:0] txn_addr_q;
  logic [data_width-1:0]    txn_data_q;
  logic                     txn_we_q;
  logic                     accept, capture, pass_through;

  assign accept       = (state_q == ARB_EXT_IDLE) && ext_valid_i;
  assign capture      = (state_q == ARB_EXT_RESP) && !module_busy_i;
  assign pass_through = (state_q == ARB_CPU) || (state_q == ARB_DRAIN) || (state_q == ARB_COOL);
  assign burst_inc    = burst_q + 1'b1;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ARB_CPU:      if (ext_req_i) state_d = ARB_DRAIN;
      // slot_q doubles as the drain-cycle counter; nonzero means two cycles have passed
      ARB_DRAIN: begin
        if (!ext_req_i)                           state_d = ARB_CPU;
        else if ((slot_q != '0) && !module_busy_i) state_d = ARB_EXT_IDLE;
      end
      ARB_EXT_IDLE: begin
        if (accept)          state_d = ARB_EXT_ACC;
        else if (!ext_req_i) state_d = ARB_CPU;
      end
      ARB_EXT_ACC:  state_d = ARB_EXT_RESP;
      ARB_EXT_RESP: begin
        if (capture) begin
          burst_d = burst_inc;
          if ((MAX_BURST != 0) && (burst_inc == BURST_LIMIT)) state_d = ARB_COOL;
          else                                                state_d = ARB_EXT_IDLE;
        end
      end
      ARB_COOL:     if (slot_q == SLOT_LAST) state_d = ext_req_i ? ARB_DRAIN : ARB_CPU;
      default:      state_d = ARB_CPU;
    endcase
    if ((state_d == ARB_CPU) || (state_d == ARB_COOL)) burst_d = '0;
  end

  always_comb begin
    if (state_d != state_q)             slot_d = '0;
    else if (slot_q != {SLOT_W{1'b1}})  slot_d = slot_q + 1'b1;
    else                                slot_d = slot_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ARB_CPU;
      burst_q  <= '0;
      slot_q   <= '0;
      halt_q   <= 1'b0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      txn_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      slot_q   <= slot_d;
      halt_q   <= (state_d != ARB_CPU) && (state_d != ARB_COOL);
      gnt_q    <= (state_d == ARB_EXT_IDLE) || (state_d == ARB_EXT_ACC) ||
                  (state_d == ARB_EXT_RESP);
      rvalid_q <= capture;
      if (capture) rdata_q  <= bus_rdata_i;
      if (accept)  txn_we_q <= ext_we_i;
    end
  end

  // Address/data latch tracks the CPU while it drives, so EXT_IDLE holds the last bus values
  always_ff @(posedge clk_i) begin
    if (accept) begin
      txn_addr_q <= ext_address_i;
      txn_data_q <= ext_wdata_i;
    end else if (pass_through) begin
      txn_addr_q <= cpu_address_i;
      txn_data_q <= cpu_data_i;
    end
  end

  always_comb begin
    if (pass_through) begin
      bus_address_o = cpu_address_i;
      bus_we_o      = cpu_we_i;
      bus_we_ram_o  = cpu_we_ram_i;
      bus_data_o    = cpu_data_i;
    end else begin
      bus_address_o = txn_addr_q;
      bus_we_o      = (state_q == ARB_EXT_ACC) && txn_we_q;
      bus_we_ram_o  = ((state_q == ARB_EXT_ACC) && txn_we_q) ? 4'hF : 4'h0;
      bus_data_o    = txn_data_q;
    end
  end

  assign ext_ready_o  = (state_q == ARB_EXT_IDLE);
  assign cpu_halt_o   = halt_q;
  assign ext_gnt_o    = gnt_q;
  assign ext_rvalid_o = rvalid_q;
  assign ext_rdata_o  = rdata_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: stimulus queues expected read data, a
// negedge monitor checks every completion pulse against the queue.
module tb_bus_master_arbiter;
  import cpu_reg_package::*;

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic [address_width-1:0] cpu_address_i;
  logic                     cpu_we_i;
  logic [3:0]               cpu_we_ram_i;
  logic [data_width-1:0]    cpu_data_i;
  logic                     cpu_halt_o;
  logic                     ext_req_i;
  logic                     ext_gnt_o;
  logic                     ext_valid_i;
  logic                     ext_ready_o;
  logic [address_width-1:0] ext_address_i;
  logic                     ext_we_i;
  logic [data_width-1:0]    ext_wdata_i;
  logic [data_width-1:0]    ext_rdata_o;
  logic                     ext_rvalid_o;
  logic [address_width-1:0] bus_address_o;
  logic                     bus_we_o;
  logic [3:0]               bus_we_ram_o;
  logic [data_width-1:0]    bus_data_o;
  logic [data_width-1:0]    bus_rdata_i;
  logic                     module_busy_i;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  bus_master_arbiter #(.MAX_BURST(2), .CPU_SLOT(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cpu_address_i(cpu_address_i), .cpu_we_i(cpu_we_i), .cpu_we_ram_i(cpu_we_ram_i),
    .cpu_data_i(cpu_data_i), .cpu_halt_o(cpu_halt_o),
    .ext_req_i(ext_req_i), .ext_gnt_o(ext_gnt_o), .ext_valid_i(ext_valid_i),
    .ext_ready_o(ext_ready_o), .ext_address_i(ext_address_i), .ext_we_i(ext_we_i),
    .ext_wdata_i(ext_wdata_i), .ext_rdata_o(ext_rdata_o), .ext_rvalid_o(ext_rvalid_o),
    .bus_address_o(bus_address_o), .bus_we_o(bus_we_o), .bus_we_ram_o(bus_we_ram_o),
    .bus_data_o(bus_data_o), .bus_rdata_i(bus_rdata_i), .module_busy_i(module_busy_i)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every rvalid pulse must match the oldest queued read word
  always @(negedge clk) begin
    if (ext_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rdata %h expected no completion", ext_rdata_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check32("rvalid_rdata", ext_rdata_o, mon_exp);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ext_ready_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (ext_ready_o !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got ready %b expected 1 within 30 cycles", ext_ready_o);
    end
  endtask

  // Issues one transaction in EXT_IDLE and returns in the EXT_ACC cycle
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] rd, input bit push);
    wait_ready();
    bus_rdata_i   = rd;
    ext_address_i = a;
    ext_we_i      = w;
    ext_wdata_i   = wd;
    ext_valid_i   = 1'b1;
    if (push) exp_q.push_back(rd);
    tick();
    ext_valid_i = 1'b0;
    check32("acc_addr", bus_address_o, a);
    check1("acc_we", bus_we_o, w);
    check32("acc_we_ram", 32'(bus_we_ram_o), w ? 32'hF : 32'h0);
    if (w) check32("acc_data", bus_data_o, wd);
    check1("acc_ready", ext_ready_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; cpu_address_i = '0; cpu_we_i = 1'b0; cpu_we_ram_i = 4'h0;
    cpu_data_i = '0; ext_req_i = 1'b0; ext_valid_i = 1'b0; ext_address_i = '0;
    ext_we_i = 1'b0; ext_wdata_i = '0; bus_rdata_i = '0; module_busy_i = 1'b0;
    tick(); tick();
    check1("rst_halt", cpu_halt_o, 1'b0);
    check1("rst_gnt", ext_gnt_o, 1'b0);
    check1("rst_rvalid", ext_rvalid_o, 1'b0);
    check1("rst_ready", ext_ready_o, 1'b0);
    check32("rst_rdata", ext_rdata_o, 32'h0);
    reset_i = 1'b0;

    // Idle CPU path
    cpu_address_i = 32'h0100; cpu_we_i = 1'b1; cpu_we_ram_i = 4'hF; cpu_data_i = 32'hDEADBEEF;
    #1;
    check32("cpu_addr", bus_address_o, 32'h0100);
    check1("cpu_we", bus_we_o, 1'b1);
    check32("cpu_we_ram", 32'(bus_we_ram_o), 32'hF);
    check32("cpu_data", bus_data_o, 32'hDEADBEEF);
    repeat (3) begin
      tick();
      check1("idle_halt", cpu_halt_o, 1'b0);
    end
    cpu_we_i = 1'b0; cpu_we_ram_i = 4'h0;

    // Grant with drain: request at t, busy high t..t+4
    module_busy_i = 1'b1; ext_req_i = 1'b1;
    tick();
    check1("drain_halt", cpu_halt_o, 1'b1);
    check1("drain_gnt_t1", ext_gnt_o, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check1("drain_gnt_early", ext_gnt_o, 1'b0);
      if (i == 5) module_busy_i = 1'b0;
    end
    tick();
    check1("grant_gnt", ext_gnt_o, 1'b1);
    check1("grant_ready", ext_ready_o, 1'b1);
    check1("grant_halt", cpu_halt_o, 1'b1);
    cpu_we_i = 1'b1; cpu_address_i = 32'h0200;
    #1;
    check1("ext_idle_we_gated", bus_we_o, 1'b0);
    check32("ext_idle_addr_hold", bus_address_o, 32'h0100);
    cpu_we_i = 1'b0;

    // External read at 0x0040
    issue(32'h0040, 1'b0, 32'h0, 32'h12345678, 1'b1);
    tick();
    check1("resp_we", bus_we_o, 1'b0);
    check1("resp_rvalid_early", ext_rvalid_o, 1'b0);
    tick();
    check1("read_rvalid", ext_rvalid_o, 1'b1);
    check1("read_ready", ext_ready_o, 1'b1);
    check32("read_rdata", ext_rdata_o, 32'h12345678);
    check32("read_addr_hold", bus_address_o, 32'h0040);
    ext_req_i = 1'b0;
    tick();
    check1("release_gnt", ext_gnt_o, 1'b0);
    check1("release_halt", cpu_halt_o, 1'b0);
    check1("release_rvalid", ext_rvalid_o, 1'b0);

    // Burst limit of 2 with a 4-cycle CPU slot
    ext_req_i = 1'b1;
    tick(); tick();
    issue(32'h0300, 1'b1, 32'hA1, 32'hC1, 1'b1);
    tick();
    issue(32'h0304, 1'b1, 32'hA2, 32'hC2, 1'b1);
    tick();
    tick();
    check1("cool_rvalid", ext_rvalid_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check1("cool_gnt", ext_gnt_o, 1'b0);
      check1("cool_halt", cpu_halt_o, 1'b0);
      tick();
    end
    check1("redrain_halt", cpu_halt_o, 1'b1);
    check1("redrain_gnt", ext_gnt_o, 1'b0);
    issue(32'h0308, 1'b1, 32'hA3, 32'hC3, 1'b1);
    tick();
    ext_req_i = 1'b0;
    tick();
    check1("burst3_rvalid", ext_rvalid_o, 1'b1);
    tick();
    check1("burst_end_gnt", ext_gnt_o, 1'b0);
    check1("burst_end_halt", cpu_halt_o, 1'b0);

    // Release during EXT_RESP with busy stretched 3 cycles
    ext_req_i = 1'b1;
    issue(32'h0080, 1'b0, 32'h0, 32'h0BADF00D, 1'b1);
    tick();
    ext_req_i = 1'b0; module_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("stretch_rvalid", ext_rvalid_o, 1'b0);
      check1("stretch_gnt", ext_gnt_o, 1'b1);
    end
    module_busy_i = 1'b0;
    tick();
    check1("stretch_done_rvalid", ext_rvalid_o, 1'b1);
    tick();
    check1("stretch_cpu_gnt", ext_gnt_o, 1'b0);
    check1("stretch_cpu_halt", cpu_halt_o, 1'b0);

    // Reset in EXT_ACC drops the transaction
    ext_req_i = 1'b1;
    issue(32'h0090, 1'b1, 32'h55, 32'h0, 1'b0);
    reset_i = 1'b1;
    tick();
    check1("mid_rst_gnt", ext_gnt_o, 1'b0);
    check1("mid_rst_halt", cpu_halt_o, 1'b0);
    check1("mid_rst_rvalid", ext_rvalid_o, 1'b0);
    cpu_address_i = 32'h0400; cpu_we_i = 1'b1; cpu_we_ram_i = 4'h3; cpu_data_i = 32'h77;
    #1;
    check32("mid_rst_addr", bus_address_o, 32'h0400);
    check1("mid_rst_we", bus_we_o, 1'b1);
    check32("mid_rst_we_ram", 32'(bus_we_ram_o), 32'h3);
    check32("mid_rst_data", bus_data_o, 32'h77);
    reset_i = 1'b0; ext_req_i = 1'b0; cpu_we_i = 1'b0; cpu_we_ram_i = 4'h0;
    repeat (4) tick();
    check1("post_rst_rvalid", ext_rvalid_o, 1'b0);
    check32("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
